ex_mem_stage: RTL and testbench

Execute-to-memory pipeline stage of the RV32I core. It captures the 32-bit result and the C/V/N/Z flags from the execute-stage add/subtract unit, resolves conditional branches from those flags, and produces a registered PC redirect. It holds the instruction in a valid/ready register slice until the memory stage accepts it, and keeps a saturating taken-branch counter.

---
 rtl/ex_mem_stage.sv | 121 ++++++++++++
 tb/tb_ex_mem_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// Execute-to-memory stage: captures adder result/flags, resolves branches, holds entry in a valid/ready slice.
// Latency: one cycle from accept to mem_valid_o, payload, redirect_o and misalign_o.
// Backpressure: ex_ready_o = !mem_valid_o || mem_ready_i; entry and outputs hold while stalled.
module ex_mem_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid_i,
   output logic            ex_ready_o,
   input  logic [XLEN-1:0] y_i,
   input  logic            c_i,
   input  logic            v_i,
   input  logic            n_i,
   input  logic            z_i,
   input  logic            is_branch_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [4:0]      rd_i,
   input  logic            reg_write_i,
   input  logic            mem_ready_i,
   output logic            mem_valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o,
   output logic            reg_write_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            misalign_o,
   output logic [XLEN-1:0] taken_cnt_o
);

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [4:0]      rd;
      logic            reg_write;
      logic [XLEN-1:0] target;
   } slot_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   logic            accept;
   logic            taken;
   logic            aligned;
   logic [XLEN-1:0] target;
   slot_t           slot_d;
   slot_t           slot_q;
   logic            valid_q;
   logic            redirect_q;
   logic            misalign_q;
   logic [XLEN-1:0] taken_cnt_q;

   assign ex_ready_o = !valid_q || mem_ready_i;
   assign accept     = ex_valid_i && ex_ready_o;
   assign target     = pc_i + imm_i;
   assign aligned    = (target[1:0] == 2'b00);

   // Flags come from rs1 - rs2; C is the unsigned borrow.
   always_comb begin
      taken = 1'b0;
      if (is_branch_i) begin
         case (funct3_i)
            F3_BEQ:  taken = z_i;
            F3_BNE:  taken = !z_i;
            F3_BLT:  taken = n_i ^ v_i;
            F3_BGE:  taken = !(n_i ^ v_i);
            F3_BLTU: taken = c_i;
            F3_BGEU: taken = !c_i;
            default: taken = 1'b0;
         endcase
      end
   end

   always_comb begin
      slot_d           = slot_q;
      slot_d.result    = y_i;
      slot_d.rd        = rd_i;
      slot_d.reg_write = reg_write_i && !is_branch_i;
      slot_d.target    = target;
   end

   // Pulses are set only on the accepting edge, so a stalled entry never re-fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         slot_q      <= '0;
         redirect_q  <= 1'b0;
         misalign_q  <= 1'b0;
         taken_cnt_q <= '0;
      end else if (accept) begin
         valid_q    <= 1'b1;
         slot_q     <= slot_d;
         redirect_q <= taken && aligned;
         misalign_q <= taken && !aligned;
         if (taken && (taken_cnt_q != '1)) begin
            taken_cnt_q <= taken_cnt_q + XLEN'(1);
         end
      end else begin
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
         if (mem_ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign mem_valid_o   = valid_q;
   assign result_o      = slot_q.result;
   assign rd_o          = slot_q.rd;
   assign reg_write_o   = slot_q.reg_write;
   assign redirect_pc_o = slot_q.target;
   assign redirect_o    = redirect_q;
   assign misalign_o    = misalign_q;
   assign taken_cnt_o   = taken_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage against a compare-based branch/slice model.
// Latency: model advances one step per clock; Backpressure: mem_ready_i driven randomly and directed.
module tb_ex_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        ex_valid_i;
   logic        ex_ready_o;
   logic [31:0] y_i;
   logic        c_i, v_i, n_i, z_i;
   logic        is_branch_i;
   logic [2:0]  funct3_i;
   logic [31:0] pc_i;
   logic [31:0] imm_i;
   logic [4:0]  rd_i;
   logic        reg_write_i;
   logic        mem_ready_i;
   logic        mem_valid_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;
   logic        reg_write_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        misalign_o;
   logic [31:0] taken_cnt_o;

   ex_mem_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
      .y_i(y_i), .c_i(c_i), .v_i(v_i), .n_i(n_i), .z_i(z_i),
      .is_branch_i(is_branch_i), .funct3_i(funct3_i),
      .pc_i(pc_i), .imm_i(imm_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
      .mem_ready_i(mem_ready_i), .mem_valid_o(mem_valid_o),
      .result_o(result_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
      .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
      .misalign_o(misalign_o), .taken_cnt_o(taken_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference state: what the stage should present after the most recent edge.
   logic        m_valid, m_rw, m_redir, m_mis;
   logic [31:0] m_result, m_pc, m_cnt;
   logic [4:0]  m_rd;
   logic [31:0] op_a, op_b;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) <  $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a <  b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_rw = 0; m_redir = 0; m_mis = 0;
      m_result = 0; m_pc = 0; m_cnt = 0; m_rd = 0;
   endtask

   task automatic set_branch(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                             input logic [31:0] pc, input logic [31:0] imm);
      logic [31:0] d;
      d = a - b;
      op_a = a; op_b = b;
      ex_valid_i = 1; is_branch_i = 1; funct3_i = f3;
      y_i = d; z_i = (d == 0); n_i = d[31]; c_i = (a < b);
      v_i = (a[31] != b[31]) && (d[31] != a[31]);
      pc_i = pc; imm_i = imm;
      rd_i = 5'($urandom); reg_write_i = 1;
   endtask

   task automatic set_alu(input logic [31:0] y, input logic [4:0] rd, input logic rw);
      ex_valid_i = 1; is_branch_i = 0; funct3_i = 3'($urandom);
      y_i = y; rd_i = rd; reg_write_i = rw;
      {c_i, v_i, n_i, z_i} = 4'($urandom);
      pc_i = $urandom; imm_i = $urandom;
   endtask

   task automatic check_outputs(input string pfx);
      chk({pfx, ".valid"},  32'(mem_valid_o),  32'(m_valid));
      chk({pfx, ".result"}, result_o,          m_result);
      chk({pfx, ".rd"},     32'(rd_o),         32'(m_rd));
      chk({pfx, ".rw"},     32'(reg_write_o),  32'(m_rw));
      chk({pfx, ".redir"},  32'(redirect_o),   32'(m_redir));
      chk({pfx, ".mis"},    32'(misalign_o),   32'(m_mis));
      chk({pfx, ".tpc"},    redirect_pc_o,     m_pc);
      chk({pfx, ".cnt"},    taken_cnt_o,       m_cnt);
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic cycle(input string pfx);
      logic        rdy, tk;
      logic [31:0] tgt;
      #1;
      rdy = !m_valid || mem_ready_i;
      chk({pfx, ".ready"}, 32'(ex_ready_o), 32'(rdy));
      if (ex_valid_i && rdy) begin
         tgt      = pc_i + imm_i;
         tk       = is_branch_i && ref_taken(funct3_i, op_a, op_b);
         m_valid  = 1;
         m_result = y_i;
         m_rd     = rd_i;
         m_rw     = reg_write_i && !is_branch_i;
         m_pc     = tgt;
         m_redir  = tk && (tgt % 4 == 0);
         m_mis    = tk && (tgt % 4 != 0);
         if (tk && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else begin
         m_redir = 0;
         m_mis   = 0;
         if (mem_ready_i) m_valid = 0;
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs(pfx);
   endtask

   task automatic idle();
      ex_valid_i = 0; is_branch_i = 0; mem_ready_i = 1;
   endtask

   initial begin
      rst_n = 0; ex_valid_i = 0; y_i = 0; {c_i, v_i, n_i, z_i} = 0;
      is_branch_i = 0; funct3_i = 0; pc_i = 0; imm_i = 0; rd_i = 0;
      reg_write_i = 0; mem_ready_i = 0; op_a = 0; op_b = 0;
      model_reset();
      #12;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1;
      #1 chk("post_reset_ready", 32'(ex_ready_o), 32'd1);

      // BEQ taken to 0x120
      @(negedge clk);
      mem_ready_i = 1;
      set_branch(32'd7, 32'd7, 3'b000, 32'h100, 32'h20);
      cycle("beq");
      chk("beq_redirect", 32'(redirect_o), 32'd1);
      chk("beq_target", redirect_pc_o, 32'h120);
      chk("beq_rw", 32'(reg_write_o), 32'd0);
      chk("beq_cnt", taken_cnt_o, 32'd1);
      idle();
      cycle("beq_after");
      chk("beq_one_pulse", 32'(redirect_o), 32'd0);

      // Signed vs unsigned compare of 0xFFFFFFFF against 1
      set_branch(32'hFFFF_FFFF, 32'd1, 3'b100, 32'h400, 32'h10);
      cycle("blt");
      chk("blt_taken", 32'(redirect_o), 32'd1);
      set_branch(32'hFFFF_FFFF, 32'd1, 3'b110, 32'h400, 32'h10);
      cycle("bltu");
      chk("bltu_not_taken", 32'(redirect_o), 32'd0);
      chk("blt_bltu_cnt", taken_cnt_o, 32'd2);

      // Stall with an ALU op held for four cycles
      set_alu(32'h1234, 5'd5, 1'b1);
      cycle("stall_acc");
      set_alu(32'hDEAD_BEEF, 5'd9, 1'b1);
      mem_ready_i = 0;
      for (int i = 0; i < 4; i++) begin
         cycle("stall");
         chk("stall_result", result_o, 32'h1234);
         chk("stall_rd", 32'(rd_o), 32'd5);
         chk("stall_ready", 32'(ex_ready_o), 32'd0);
      end
      idle();
      cycle("stall_rel");
      chk("stall_drained", 32'(mem_valid_o), 32'd0);

      // Back-to-back stream with one taken branch in slot 3
      for (int i = 0; i < 8; i++) begin
         mem_ready_i = 1;
         if (i == 3) set_branch(32'd42, 32'd42, 3'b000, 32'h800, 32'h40);
         else        set_alu($urandom, 5'(i), 1'b1);
         cycle("b2b");
         chk("b2b_valid", 32'(mem_valid_o), 32'd1);
         chk("b2b_redir", 32'(redirect_o), (i == 3) ? 32'd1 : 32'd0);
      end
      idle();
      cycle("b2b_end");

      // Misaligned taken BNE, then reserved funct3
      set_branch(32'd1, 32'd2, 3'b001, 32'h200, 32'h6);
      cycle("mis");
      chk("mis_pulse", 32'(misalign_o), 32'd1);
      chk("mis_no_redir", 32'(redirect_o), 32'd0);
      chk("mis_cnt", taken_cnt_o, 32'd4);
      set_branch(32'd5, 32'd5, 3'b010, 32'h300, 32'h8);
      cycle("f3_010");
      chk("f3_010_redir", 32'(redirect_o), 32'd0);
      chk("f3_010_mis", 32'(misalign_o), 32'd0);

      // Saturation from a preloaded counter
      idle();
      force dut.taken_cnt_q = 32'hFFFF_FFFE;
      #1 release dut.taken_cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      set_branch(32'd3, 32'd9, 3'b110, 32'h40, 32'h4);
      cycle("sat1");
      chk("sat_reach", taken_cnt_o, 32'hFFFF_FFFF);
      set_branch(32'd3, 32'd9, 3'b110, 32'h40, 32'h4);
      cycle("sat2");
      chk("sat_hold", taken_cnt_o, 32'hFFFF_FFFF);

      // Asynchronous reset during a stall
      set_alu(32'hCAFE_0001, 5'd17, 1'b1);
      cycle("rst_acc");
      ex_valid_i = 0; mem_ready_i = 0;
      cycle("rst_stall");
      #2 rst_n = 0;
      #1;
      model_reset();
      check_outputs("rst_mid");
      chk("rst_mid_ready", 32'(ex_ready_o), 32'd1);
      @(negedge clk);
      rst_n = 1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         mem_ready_i = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) == 0) begin
            ex_valid_i = 0; is_branch_i = 0;
         end else if ($urandom_range(0, 9) < 5) begin
            logic [31:0] a, b, imm;
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = {{19{1'b0}}, 13'($urandom)};
            imm = {{19{imm[12]}}, imm[12:0]};
            if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
            set_branch(a, b, 3'($urandom), {$urandom} & 32'hFFFF_FFFC, imm);
         end else begin
            set_alu($urandom, 5'($urandom), 1'($urandom));
         end
         cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
